chip_reset_sequencer: RTL and testbench

Parametrised bring-up and reset sequencer for FPGA chip tops.
- Waits for all readiness sources (clock-generator lock, configuration end-of-startup, external reset, ...) to be stable.
- Releases the external memory controller's reset and supervises its calibration, with timeout and bounded retries.
- Releases N downstream reset domains (SoC core, peripherals, memory AXI fabric) in fixed order with programmable spacing.
- Replaces ad-hoc OR-of-not reset logic in the top level and adds the ordering, retry, fault and software-restart behaviour that logic lacks.

---
 rtl/chip_reset_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_chip_reset_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/chip_reset_sequencer.sv
// ----------------------------------------------------------------------------
// chip_reset_sequencer
//
// Bring-up and reset sequencer for the chip top. It waits for every readiness
// source to be stable and then releases the memory controller reset. It
// supervises calibration, with a timeout and a bounded number of retries.
// Once calibration is done it releases the downstream reset domains in order,
// with a fixed gap between releases.
//
// Ports
//   clk_i         sequencer clock
//   rst_ni        asynchronous active-low reset
//   src_ready_i   readiness sources (async, high = ready), 2-flop synchronised
//   cal_done_i    memory calibration complete (async), 2-flop synchronised
//   sw_rst_req_i  synchronous single-cycle restart request
//   mem_rst_o     active-high memory controller reset
//   dom_rst_no    active-low domain resets, bit 0 released first
//   ready_o       high in RUN only
//   fault_o       high in FAULT only
//   retry_cnt_o   calibration retries consumed
//   state_o       current state code
//
// state        | meaning
// -------------+--------------------------------------------------------------
// WAIT_SRC     | waiting for all readiness sources
// STABILIZE    | sources high; counting StableCycles before memory release
// CAL          | memory out of reset; waiting for calibration, with timeout
// RELEASE      | releasing domains one by one, ReleaseGap apart
// RUN          | everything released
// MEM_RECOVER  | calibration timed out; memory held in reset for StableCycles
// FAULT        | retries exhausted; left only by a software restart
// ----------------------------------------------------------------------------
module chip_reset_sequencer #(
    parameter int NumSrc           = 4,
    parameter int NumDomains       = 3,
    parameter int StableCycles     = 16,
    parameter int ReleaseGap       = 8,
    parameter int CalTimeoutCycles = 1000000,
    parameter int MaxRetries       = 3,
    localparam int RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumSrc-1:0]     src_ready_i,
    input  logic                  cal_done_i,
    input  logic                  sw_rst_req_i,
    output logic                  mem_rst_o,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic                  ready_o,
    output logic                  fault_o,
    output logic [RetryW-1:0]     retry_cnt_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_WAIT_SRC    = 3'd0,
        S_STABILIZE   = 3'd1,
        S_CAL         = 3'd2,
        S_RELEASE     = 3'd3,
        S_RUN         = 3'd4,
        S_MEM_RECOVER = 3'd5,
        S_FAULT       = 3'd6
    } state_e;

    // One shared down-counter serves every timed state, so it is sized for
    // the longest interval.
    localparam int CntMax0 = (StableCycles > ReleaseGap) ? StableCycles : ReleaseGap;
    localparam int CntMax  = (CntMax0 > CalTimeoutCycles) ? CntMax0 : CalTimeoutCycles;
    localparam int CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]   StableLoad = CntW'(StableCycles - 1);
    localparam logic [CntW-1:0]   CalLoad    = CntW'(CalTimeoutCycles - 1);
    localparam logic [CntW-1:0]   GapLoad    = CntW'(ReleaseGap - 1);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(MaxRetries);

    logic [NumSrc-1:0]     src_meta_q, src_sync_q;
    logic                  cal_meta_q, cal_sync_q;
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [RetryW-1:0]     retry_cnt_q, retry_cnt_d;
    logic [NumDomains-1:0] dom_rst_q, dom_rst_d;
    logic                  mem_rst_q, mem_rst_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic                  all_ok;

    assign all_ok = &src_sync_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_cnt_d = retry_cnt_q;
        dom_rst_d   = dom_rst_q;

        case (state_q)
            S_WAIT_SRC: begin
                if (all_ok) state_d = S_STABILIZE;
            end
            S_STABILIZE: begin
                if (!all_ok)              state_d = S_WAIT_SRC;
                else if (cnt_q == '0)     state_d = S_CAL;
                else                      cnt_d   = cnt_q - CntW'(1);
            end
            S_CAL: begin
                // A calibration done seen on the timeout cycle still wins.
                if (!all_ok)              state_d = S_WAIT_SRC;
                else if (cal_sync_q)      state_d = S_RELEASE;
                else if (cnt_q == '0) begin
                    if (retry_cnt_q < RetryMax) begin
                        state_d     = S_MEM_RECOVER;
                        retry_cnt_d = retry_cnt_q + RetryW'(1);
                    end else begin
                        state_d     = S_FAULT;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_RELEASE: begin
                if (!all_ok || !cal_sync_q) begin
                    state_d = S_WAIT_SRC;
                end else if (cnt_q == '0) begin
                    // Release the next domain; the shift fills from bit 0 up.
                    dom_rst_d = (dom_rst_q << 1) | NumDomains'(1);
                    if (&dom_rst_d) state_d = S_RUN;
                    else            cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_RUN: begin
                if (!all_ok || !cal_sync_q) state_d = S_WAIT_SRC;
            end
            S_MEM_RECOVER: begin
                if (cnt_q == '0) state_d = S_WAIT_SRC;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_WAIT_SRC;
            end
        endcase

        if (sw_rst_req_i) begin
            state_d     = S_WAIT_SRC;
            retry_cnt_d = '0;
        end

        if (state_d != state_q) begin
            case (state_d)
                S_STABILIZE, S_MEM_RECOVER: cnt_d = StableLoad;
                S_CAL:                      cnt_d = CalLoad;
                S_RELEASE:                  cnt_d = GapLoad;
                default:                    cnt_d = cnt_q;
            endcase
        end

        // Domains stay released only while releasing or running.
        if (state_d != S_RELEASE && state_d != S_RUN) dom_rst_d = '0;

        mem_rst_d = (state_d == S_WAIT_SRC) || (state_d == S_STABILIZE) ||
                    (state_d == S_MEM_RECOVER) || (state_d == S_FAULT);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_meta_q  <= '0;
            src_sync_q  <= '0;
            cal_meta_q  <= 1'b0;
            cal_sync_q  <= 1'b0;
            state_q     <= S_WAIT_SRC;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            dom_rst_q   <= '0;
            mem_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            src_meta_q  <= src_ready_i;
            src_sync_q  <= src_meta_q;
            cal_meta_q  <= cal_done_i;
            cal_sync_q  <= cal_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            dom_rst_q   <= dom_rst_d;
            mem_rst_q   <= mem_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_rst_o   = mem_rst_q;
    assign dom_rst_no  = dom_rst_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_chip_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_chip_reset_sequencer
//
// Directed bench for chip_reset_sequencer with NumSrc=2, NumDomains=3,
// StableCycles=4, ReleaseGap=2, CalTimeoutCycles=10, MaxRetries=1.
// Edge numbers in comments count rising edges from the reference point that
// do_reset leaves behind. Inputs are driven and outputs sampled 1 time unit
// after a rising edge.
// ----------------------------------------------------------------------------
module tb_chip_reset_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] src_ready_i;
    logic       cal_done_i;
    logic       sw_rst_req_i;
    logic       mem_rst_o;
    logic [2:0] dom_rst_no;
    logic       ready_o;
    logic       fault_o;
    logic [0:0] retry_cnt_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    chip_reset_sequencer #(
        .NumSrc           (2),
        .NumDomains       (3),
        .StableCycles     (4),
        .ReleaseGap       (2),
        .CalTimeoutCycles (10),
        .MaxRetries       (1)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .src_ready_i  (src_ready_i),
        .cal_done_i   (cal_done_i),
        .sw_rst_req_i (sw_rst_req_i),
        .mem_rst_o    (mem_rst_o),
        .dom_rst_no   (dom_rst_no),
        .ready_o      (ready_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench 1 unit after edge 0, with the sequencer in WAIT_SRC.
    task automatic do_reset();
        rst_ni       = 1'b0;
        src_ready_i  = 2'b00;
        cal_done_i   = 1'b0;
        sw_rst_req_i = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_ni       = 1'b1;
        src_ready_i  = 2'b00;
        cal_done_i   = 1'b0;
        sw_rst_req_i = 1'b0;

        // Reset values, applied before any clock edge
        #2 rst_ni = 1'b0;
        #1;
        check_val("rst_state",   int'(state_o),     0);
        check_val("rst_mem_rst", int'(mem_rst_o),   1);
        check_val("rst_dom",     int'(dom_rst_no),  0);
        check_val("rst_ready",   int'(ready_o),     0);
        check_val("rst_fault",   int'(fault_o),     0);
        check_val("rst_retry",   int'(retry_cnt_o), 0);

        // Nominal bring-up, then loss of calibration in RUN
        do_reset();
        src_ready_i = 2'b11;
        tick(2);  check_val("nom_wait_e2", int'(state_o), 0);
        tick(1);  check_val("nom_stab_e3", int'(state_o), 1);
                  check_val("nom_mem_e3",  int'(mem_rst_o), 1);
        tick(3);  check_val("nom_stab_e6", int'(state_o), 1);
        tick(1);  check_val("nom_cal_e7",  int'(state_o), 2);
                  check_val("nom_mem_e7",  int'(mem_rst_o), 0);
        tick(3);  cal_done_i = 1'b1;
        tick(2);  check_val("nom_cal_e12", int'(state_o), 2);
        tick(1);  check_val("nom_rel_e13", int'(state_o), 3);
                  check_val("nom_dom_e13", int'(dom_rst_no), 0);
        tick(1);  check_val("nom_dom_e14", int'(dom_rst_no), 0);
        tick(1);  check_val("nom_dom_e15", int'(dom_rst_no), 1);
                  check_val("nom_rdy_e15", int'(ready_o), 0);
        tick(2);  check_val("nom_dom_e17", int'(dom_rst_no), 3);
                  check_val("nom_rel_e17", int'(state_o), 3);
        tick(1);  check_val("nom_dom_e18", int'(dom_rst_no), 3);
        tick(1);  check_val("nom_dom_e19", int'(dom_rst_no), 7);
                  check_val("nom_run_e19", int'(state_o), 4);
                  check_val("nom_rdy_e19", int'(ready_o), 1);
                  check_val("nom_mem_e19", int'(mem_rst_o), 0);
        tick(2);  cal_done_i = 1'b0;
        tick(2);  check_val("loss_rdy_e23", int'(ready_o), 1);
                  check_val("loss_run_e23", int'(state_o), 4);
        tick(1);  check_val("loss_state_e24", int'(state_o), 0);
                  check_val("loss_rdy_e24",   int'(ready_o), 0);
                  check_val("loss_dom_e24",   int'(dom_rst_no), 0);
                  check_val("loss_mem_e24",   int'(mem_rst_o), 1);

        // Source glitch during STABILIZE restarts the stability count
        do_reset();
        src_ready_i = 2'b11;
        tick(3);  check_val("gl_stab_e3", int'(state_o), 1);
        tick(1);  src_ready_i = 2'b01;
        tick(1);  src_ready_i = 2'b11;
        tick(1);  check_val("gl_stab_e6", int'(state_o), 1);
                  check_val("gl_mem_e6",  int'(mem_rst_o), 1);
        tick(1);  check_val("gl_wait_e7", int'(state_o), 0);
                  check_val("gl_mem_e7",  int'(mem_rst_o), 1);
        tick(1);  check_val("gl_stab_e8", int'(state_o), 1);
        tick(3);  check_val("gl_stab_e11", int'(state_o), 1);
                  check_val("gl_mem_e11",  int'(mem_rst_o), 1);
        tick(1);  check_val("gl_cal_e12", int'(state_o), 2);
                  check_val("gl_mem_e12", int'(mem_rst_o), 0);

        // Calibration timeout, recovery, then a successful second attempt
        do_reset();
        src_ready_i = 2'b11;
        tick(16); check_val("rt_cal_e16",   int'(state_o), 2);
                  check_val("rt_retry_e16", int'(retry_cnt_o), 0);
        tick(1);  check_val("rt_rec_e17",   int'(state_o), 5);
                  check_val("rt_retry_e17", int'(retry_cnt_o), 1);
                  check_val("rt_mem_e17",   int'(mem_rst_o), 1);
        tick(3);  check_val("rt_rec_e20",   int'(state_o), 5);
                  check_val("rt_mem_e20",   int'(mem_rst_o), 1);
        tick(1);  check_val("rt_wait_e21",  int'(state_o), 0);
                  cal_done_i = 1'b1;
        tick(1);  check_val("rt_stab_e22",  int'(state_o), 1);
        tick(4);  check_val("rt_cal_e26",   int'(state_o), 2);
                  check_val("rt_mem_e26",   int'(mem_rst_o), 0);
        tick(1);  check_val("rt_rel_e27",   int'(state_o), 3);
        tick(6);  check_val("rt_run_e33",   int'(state_o), 4);
                  check_val("rt_rdy_e33",   int'(ready_o), 1);
                  check_val("rt_retry_e33", int'(retry_cnt_o), 1);
                  check_val("rt_dom_e33",   int'(dom_rst_no), 7);

        // Retry exhaustion into FAULT, cleared by a software restart
        do_reset();
        src_ready_i = 2'b11;
        tick(35); check_val("ex_cal_e35",   int'(state_o), 2);
                  check_val("ex_retry_e35", int'(retry_cnt_o), 1);
        tick(1);  check_val("ex_fault_st",  int'(state_o), 6);
                  check_val("ex_fault_o",   int'(fault_o), 1);
                  check_val("ex_fault_mem", int'(mem_rst_o), 1);
                  check_val("ex_fault_dom", int'(dom_rst_no), 0);
                  check_val("ex_fault_rdy", int'(ready_o), 0);
        tick(5);  check_val("ex_fault_e41", int'(state_o), 6);
                  sw_rst_req_i = 1'b1;
        tick(1);  sw_rst_req_i = 1'b0;
                  check_val("ex_sw_state",  int'(state_o), 0);
                  check_val("ex_sw_retry",  int'(retry_cnt_o), 0);
                  check_val("ex_sw_fault",  int'(fault_o), 0);
                  check_val("ex_sw_mem",    int'(mem_rst_o), 1);
        tick(1);  check_val("ex_sw_stab",   int'(state_o), 1);

        // Software restart on the same cycle as the calibration timeout
        do_reset();
        src_ready_i = 2'b11;
        tick(16); sw_rst_req_i = 1'b1;
        tick(1);  sw_rst_req_i = 1'b0;
                  check_val("sim_state", int'(state_o), 0);
                  check_val("sim_retry", int'(retry_cnt_o), 0);
                  check_val("sim_mem",   int'(mem_rst_o), 1);

        // Asynchronous reset in the middle of RELEASE
        do_reset();
        src_ready_i = 2'b11;
        tick(10); cal_done_i = 1'b1;
        tick(5);  check_val("ar_dom_e15", int'(dom_rst_no), 1);
        tick(1);  check_val("ar_rel_e16", int'(state_o), 3);
        #2 rst_ni = 1'b0;
        #1;
        check_val("ar_state", int'(state_o),     0);
        check_val("ar_mem",   int'(mem_rst_o),   1);
        check_val("ar_dom",   int'(dom_rst_no),  0);
        check_val("ar_ready", int'(ready_o),     0);
        check_val("ar_fault", int'(fault_o),     0);
        check_val("ar_retry", int'(retry_cnt_o), 0);
        #2 rst_ni = 1'b1;
        tick(1);  check_val("ar_wait_r0",  int'(state_o), 0);
        tick(1);  check_val("ar_wait_r1",  int'(state_o), 0);
        tick(1);  check_val("ar_stab_r2",  int'(state_o), 1);
        tick(5);  check_val("ar_rel_r7",   int'(state_o), 3);
                  check_val("ar_mem_r7",   int'(mem_rst_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
